csa_accum_resolve: RTL and testbench

Sequential consumer for the 16-input adder tree's redundant output. It accepts a stream of carry-save (sum, carry) pairs and accumulates them in carry-save form, one beat per cycle with no carry propagation. On the last beat of a group it resolves the accumulator with a segmented multi-cycle carry-propagate adder and presents one binary result over a valid/ready handshake. It sits between the PE adder tree and the PE output / write-back stage.

---
 rtl/csa_acc_pkg.sv | 26 ++
 rtl/csa4_2.sv | 28 ++
 rtl/csa_accum_resolve.sv | 123 ++++++++++++
 tb/tb_csa_accum_resolve.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/csa_acc_pkg.sv
// Shared types and constants for the carry-save accumulator/resolver.
// The state encoding, segment count and beat-count saturation live here.
package csa_acc_pkg;

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_RES = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    localparam int NSEG      = 4;
    localparam int SEG_CNT_W = $clog2(NSEG);
    localparam logic [7:0] CNT_MAX = 8'd255;

    // Beat counter increment that sticks at CNT_MAX.
    function automatic logic [7:0] cnt_sat_inc(input logic [7:0] cnt);
        logic [7:0] nxt;
        if (cnt == CNT_MAX) begin
            nxt = cnt;
        end else begin
            nxt = cnt + 8'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/csa4_2.sv
// 4:2 carry-save compressor built from two cascaded 3:2 rows.
// o_sum + o_carry == i_a + i_b + i_c + i_d modulo 2^W.
module csa4_2 #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_carry
);

    logic [W-1:0] w_s1;
    logic [W-2:0] w_c1;
    logic [W-1:0] w_c1_sh;
    logic [W-2:0] w_c2;

    // Carries out of the top bit are dropped, so only W-1 majority bits are built.
    assign w_s1    = i_a ^ i_b ^ i_c;
    assign w_c1    = (i_a[W-2:0] & i_b[W-2:0]) | (i_a[W-2:0] & i_c[W-2:0]) | (i_b[W-2:0] & i_c[W-2:0]);
    assign w_c1_sh = {w_c1, 1'b0};

    assign o_sum   = w_s1 ^ i_d ^ w_c1_sh;
    assign w_c2    = (w_s1[W-2:0] & i_d[W-2:0]) | (w_s1[W-2:0] & w_c1_sh[W-2:0]) | (i_d[W-2:0] & w_c1_sh[W-2:0]);
    assign o_carry = {w_c2, 1'b0};

endmodule

// File: rtl/csa_accum_resolve.sv
// Accumulates a stream of carry-save beats without carry propagation, then
// resolves the group with a segmented multi-cycle adder and hands it downstream.
module csa_accum_resolve
    import csa_acc_pkg::*;
#(
    parameter int WIDTH = 109,
    parameter int ACC_W = 116,
    parameter int SEG_W = 29
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [7:0]       out_cnt
);

    state_t                 r_state;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [ACC_W-1:0]       r_acc_s;
    logic [ACC_W-1:0]       r_acc_c;
    logic [ACC_W-1:0]       r_res;
    logic [7:0]             r_cnt;
    logic [SEG_CNT_W-1:0]   r_seg;
    logic                   r_cy;

    logic [ACC_W-1:0]       w_ext_sum;
    logic [ACC_W-1:0]       w_ext_carry;
    logic [ACC_W-1:0]       w_cmp_s;
    logic [ACC_W-1:0]       w_cmp_c;
    logic [SEG_W-1:0]       w_seg_s;
    logic [SEG_W-1:0]       w_seg_c;
    logic [SEG_W:0]         w_seg_add;

    // Each redundant vector is sign-extended on its own before compression.
    assign w_ext_sum   = {{(ACC_W-WIDTH){in_sum[WIDTH-1]}}, in_sum};
    assign w_ext_carry = {{(ACC_W-WIDTH){in_carry[WIDTH-1]}}, in_carry};

    csa4_2 #(
        .W (ACC_W)
    ) u_csa (
        .i_a     (r_acc_s),
        .i_b     (r_acc_c),
        .i_c     (w_ext_sum),
        .i_d     (w_ext_carry),
        .o_sum   (w_cmp_s),
        .o_carry (w_cmp_c)
    );

    assign w_seg_s   = r_acc_s[int'(r_seg)*SEG_W +: SEG_W];
    assign w_seg_c   = r_acc_c[int'(r_seg)*SEG_W +: SEG_W];
    assign w_seg_add = {1'b0, w_seg_s} + {1'b0, w_seg_c} + {{SEG_W{1'b0}}, r_cy};

    // Control FSM together with accumulator, resolver and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ACC;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_acc_s     <= {ACC_W{1'b0}};
            r_acc_c     <= {ACC_W{1'b0}};
            r_res       <= {ACC_W{1'b0}};
            r_cnt       <= 8'd0;
            r_seg       <= {SEG_CNT_W{1'b0}};
            r_cy        <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (in_valid) begin
                        r_acc_s <= w_cmp_s;
                        r_acc_c <= w_cmp_c;
                        r_cnt   <= cnt_sat_inc(r_cnt);
                        if (in_last) begin
                            r_state    <= ST_RES;
                            r_in_ready <= 1'b0;
                            r_seg      <= {SEG_CNT_W{1'b0}};
                            r_cy       <= 1'b0;
                        end
                    end
                end
                ST_RES: begin
                    r_res[int'(r_seg)*SEG_W +: SEG_W] <= w_seg_add[SEG_W-1:0];
                    r_cy <= w_seg_add[SEG_W];
                    // Carry out of the top segment is discarded: arithmetic wraps.
                    if (r_seg == SEG_CNT_W'(NSEG-1)) begin
                        r_state     <= ST_OUT;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_seg <= r_seg + SEG_CNT_W'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_state     <= ST_ACC;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_acc_s     <= {ACC_W{1'b0}};
                        r_acc_c     <= {ACC_W{1'b0}};
                        r_res       <= {ACC_W{1'b0}};
                        r_cnt       <= 8'd0;
                    end
                end
                default: begin
                    r_state     <= ST_ACC;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_res;
    assign out_cnt   = r_cnt;

endmodule

// File: tb/tb_csa_accum_resolve.sv
// Directed bench for csa_accum_resolve: a modular-sum model feeds a scoreboard
// queue on each closing beat, and results are popped when out_valid appears.
module tb_csa_accum_resolve;

    localparam int WIDTH = 109;
    localparam int ACC_W = 116;

    typedef struct packed {
        logic [ACC_W-1:0] d;
        logic [7:0]       c;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic [WIDTH-1:0] in_carry;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [7:0]       out_cnt;

    int errors = 0;
    int checks = 0;

    logic [ACC_W-1:0] m_acc = '0;
    logic [7:0]       m_cnt = 8'd0;
    exp_t             sb[$];

    csa_accum_resolve #(.WIDTH(WIDTH), .ACC_W(ACC_W), .SEG_W(29)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [ACC_W-1:0] sext(input logic [WIDTH-1:0] v);
        return {{(ACC_W-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    task automatic check(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c, input logic last);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 20) check("ready_timeout", ACC_W'(in_ready), ACC_W'(1));
        in_valid = 1'b1;
        in_sum   = s;
        in_carry = c;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        m_acc = m_acc + sext(s) + sext(c);
        if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
        if (last) begin
            sb.push_back('{d: m_acc, c: m_cnt});
            m_acc = '0;
            m_cnt = 8'd0;
        end
    endtask

    task automatic get_result(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, ACC_W'(n), ACC_W'(4));
        check({tag, "_sb_nonempty"}, ACC_W'(sb.size() != 0), ACC_W'(1));
        e = '0;
        if (sb.size() != 0) e = sb.pop_front();
        check({tag, "_data"}, out_data, e.d);
        check({tag, "_cnt"}, ACC_W'(out_cnt), ACC_W'(e.c));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_hs_in_ready"}, ACC_W'(in_ready), ACC_W'(1));
        check({tag, "_hs_out_valid"}, ACC_W'(out_valid), ACC_W'(0));
        check({tag, "_hs_data_clr"}, out_data, '0);
    endtask

    initial begin
        logic [WIDTH-1:0] big;
        logic [ACC_W-1:0] d0;
        logic [7:0]       c0;
        logic             stable;

        rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_carry = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", ACC_W'(in_ready), ACC_W'(1));
        check("rst_out_valid", ACC_W'(out_valid), ACC_W'(0));
        check("rst_out_data", out_data, '0);
        check("rst_out_cnt", ACC_W'(out_cnt), ACC_W'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single positive beat.
        send_beat(109'd5, 109'd3, 1'b1);
        check("t1_in_ready_res", ACC_W'(in_ready), ACC_W'(0));
        get_result("t1");
        check("t1_const", out_data, 116'd8);
        handshake("t1");

        // Negative sum, independent sign extension.
        send_beat(~109'd9, 109'd3, 1'b1);
        get_result("t2");
        check("t2_const", out_data, ~116'd6);
        handshake("t2");

        // Carries rippling across all segment boundaries.
        big = (109'd1 << 108) - 109'd1;
        send_beat(big, 109'd1, 1'b0);
        send_beat(big, 109'd1, 1'b0);
        send_beat(big, 109'd1, 1'b1);
        get_result("t3");
        check("t3_const", out_data, 116'd3 << 108);
        handshake("t3");

        // Idle cycle inside a group is a no-op.
        send_beat(109'd5, 109'd3, 1'b0);
        @(posedge clk);
        #1;
        send_beat(~109'd1, 109'd0, 1'b1);
        get_result("t4");
        handshake("t4");

        // Backpressure: result held stable while out_ready stays low.
        send_beat(109'd20, 109'd22, 1'b1);
        get_result("t5");
        d0 = out_data;
        c0 = out_cnt;
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || out_data !== d0 || out_cnt !== c0) stable = 1'b0;
        end
        check("t5_stable", ACC_W'(stable), ACC_W'(1));
        check("t5_held_data", out_data, 116'd42);
        check("t5_held_cnt", ACC_W'(out_cnt), ACC_W'(1));
        handshake("t5");
        send_beat(109'd1, 109'd1, 1'b1);
        get_result("t5b");
        check("t5b_const", out_data, 116'd2);
        handshake("t5b");

        // Reset during the second resolve cycle drops the group.
        send_beat(109'd100, 109'd0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_in_ready", ACC_W'(in_ready), ACC_W'(1));
        check("t6_rst_out_valid", ACC_W'(out_valid), ACC_W'(0));
        check("t6_rst_out_data", out_data, '0);
        check("t6_rst_out_cnt", ACC_W'(out_cnt), ACC_W'(0));
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_beat(109'd7, 109'd0, 1'b1);
        get_result("t6");
        check("t6_const", out_data, 116'd7);
        handshake("t6");

        // Long group: count saturates, data does not.
        for (int i = 0; i < 300; i++) begin
            send_beat(109'd1, 109'd0, (i == 299) ? 1'b1 : 1'b0);
        end
        get_result("t7");
        check("t7_data_const", out_data, 116'd300);
        check("t7_cnt_sat", ACC_W'(out_cnt), ACC_W'(255));
        handshake("t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
